// File: rtl/scomp_io_pkg.sv
// -----------------------------------------------------------------------------
// scomp_io_pkg
// Shared definitions for the SCOMP I/O-bus mailbox responder:
//   - word offsets inside the 4-word I/O window
//   - bit positions inside the STATUS word
//   - responder FSM state encoding
// -----------------------------------------------------------------------------
package scomp_io_pkg;

    // Word offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_STATUS  = 2'd0;
    localparam logic [1:0] OFF_DATA    = 2'd1;
    localparam logic [1:0] OFF_CMD     = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    // STATUS word layout: {8'b0, count[3:0], underflow, overflow, full, empty}
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UDF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DRIVE = 2'd1,
        WR_WAIT  = 2'd2,
        DONE     = 2'd3
    } sc_state_e;

endpackage

// File: rtl/sc_sync_fifo.sv
// -----------------------------------------------------------------------------
// sc_sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle (occupancy unchanged); otherwise it is dropped and o_drop pulses.
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_push, i_push_data  write request and data
//   i_pop              read request (ignored when empty)
//   o_head             current head word (valid when !o_empty)
//   o_full, o_empty    occupancy flags
//   o_count            occupancy, 0 .. 2**AW
//   o_drop             one-cycle pulse: push lost because FIFO was full
// -----------------------------------------------------------------------------
module sc_sync_fifo #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_drop
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_pop_ok  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot the push needs.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/scomp_io_mailbox.sv
// -----------------------------------------------------------------------------
// scomp_io_mailbox
// SCOMP I/O-bus responder sitting at the far end of the Wishbone-to-SCOMP
// bridge. Decodes a 4-word window at BASE_ADDR:
//   +0 STATUS  R: {8'b0, count, underflow, overflow, full, empty}
//              W: bit2 clears overflow, bit3 clears underflow
//   +1 DATA    R: FIFO head, popped at the strobe fall (0 + underflow if empty)
//   +2 CMD     W: latches o_cmd_data and pulses o_cmd_valid; R: o_cmd_data
//   +3 SCRATCH R/W 16-bit register
// i_sc_clk is a slow strobe sampled in the i_clk domain, never a clock.
//
// Ports:
//   i_clk, i_reset_n     system clock, asynchronous active-low reset
//   i_sc_clk             SCOMP bus strobe
//   i_sc_iocyc           I/O cycle active
//   i_sc_iowr            1 = write, 0 = read
//   i_sc_ioaddr[7:0]     I/O address
//   io_sc_iodata[15:0]   shared data bus, driven only during a decoded read
//   i_push, i_push_data  local push into the FIFO
//   o_full               FIFO full
//   o_cmd_valid          one-cycle pulse after a CMD write commits
//   o_cmd_data[15:0]     last CMD word written
// -----------------------------------------------------------------------------
module scomp_io_mailbox
    import scomp_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h40,
    parameter int         FIFO_AW   = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sc_clk,
    input  logic        i_sc_iocyc,
    input  logic        i_sc_iowr,
    input  logic [7:0]  i_sc_ioaddr,
    inout  wire  [15:0] io_sc_iodata,
    input  logic        i_push,
    input  logic [15:0] i_push_data,
    output logic        o_full,
    output logic        o_cmd_valid,
    output logic [15:0] o_cmd_data
);

    sc_state_e r_state;
    sc_state_e w_state_nxt;

    logic        r_sc_clk_q;
    logic        r_rd_active;
    logic        r_rd_pop;
    logic [15:0] r_rd_data;
    logic        r_ovf;
    logic        r_udf;
    logic [15:0] r_scratch;
    logic [15:0] r_cmd_data;
    logic        r_cmd_valid;

    logic        w_rise;
    logic        w_fall;
    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_start_rd;
    logic        w_commit_rd;
    logic        w_commit_wr;
    logic [15:0] w_rd_mux;
    logic [15:0] w_wdata;

    logic [15:0]      w_head;
    logic             w_full;
    logic             w_empty;
    logic [FIFO_AW:0] w_count;
    logic             w_drop;
    logic             w_pop;

    assign w_rise  = i_sc_clk & ~r_sc_clk_q;
    assign w_fall  = ~i_sc_clk & r_sc_clk_q;
    assign w_hit   = i_sc_iocyc & (i_sc_ioaddr[7:2] == BASE_ADDR[7:2]);
    assign w_off   = i_sc_ioaddr[1:0];
    assign w_wdata = io_sc_iodata;

    // Gating with the live iocyc/iowr releases the bus the instant the bridge
    // ends the cycle, without waiting for the FSM to return to IDLE.
    assign io_sc_iodata = (r_rd_active & i_sc_iocyc & ~i_sc_iowr) ? r_rd_data : {16{1'bz}};

    sc_sync_fifo #(
        .DW (16),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (i_push),
        .i_push_data (i_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_drop      (w_drop)
    );

    // Whether a DATA read pops is decided at the rise, when the returned
    // word is chosen, so a push arriving before the fall cannot be lost.
    assign w_pop = w_commit_rd & r_rd_pop;

    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_off)
            OFF_STATUS: begin
                w_rd_mux[ST_EMPTY] = w_empty;
                w_rd_mux[ST_FULL]  = w_full;
                w_rd_mux[ST_OVF]   = r_ovf;
                w_rd_mux[ST_UDF]   = r_udf;
                w_rd_mux[ST_COUNT_LSB +: 4] = 4'(w_count);
            end
            OFF_DATA:    w_rd_mux = w_empty ? 16'h0000 : w_head;
            OFF_CMD:     w_rd_mux = r_cmd_data;
            OFF_SCRATCH: w_rd_mux = r_scratch;
            default:     w_rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_rd  = 1'b0;
        w_commit_rd = 1'b0;
        w_commit_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise && w_hit) begin
                    if (i_sc_iowr) begin
                        w_state_nxt = WR_WAIT;
                    end else begin
                        w_state_nxt = RD_DRIVE;
                        w_start_rd  = 1'b1;
                    end
                end
            end
            RD_DRIVE: begin
                if (!i_sc_iocyc) begin
                    w_state_nxt = IDLE;
                end else if (w_fall) begin
                    w_state_nxt = DONE;
                    w_commit_rd = 1'b1;
                end
            end
            WR_WAIT: begin
                if (!i_sc_iocyc) begin
                    w_state_nxt = IDLE;
                end else if (w_fall) begin
                    w_state_nxt = DONE;
                    w_commit_wr = 1'b1;
                end
            end
            DONE: begin
                if (!i_sc_iocyc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_sc_clk_q  <= 1'b0;
            r_rd_active <= 1'b0;
            r_rd_pop    <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_scratch   <= 16'h0000;
            r_cmd_data  <= 16'h0000;
            r_cmd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc_clk_q  <= i_sc_clk;
            r_cmd_valid <= w_commit_wr & (w_off == OFF_CMD);

            if (w_start_rd) begin
                r_rd_active <= 1'b1;
                r_rd_pop    <= (w_off == OFF_DATA) & ~w_empty;
            end else if (w_state_nxt == IDLE) begin
                r_rd_active <= 1'b0;
                r_rd_pop    <= 1'b0;
            end

            // A drop in the same cycle as a clear wins: the new event is kept.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_commit_wr && (w_off == OFF_STATUS) && w_wdata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end

            if (w_commit_rd && (w_off == OFF_DATA) && !r_rd_pop) begin
                r_udf <= 1'b1;
            end else if (w_commit_wr && (w_off == OFF_STATUS) && w_wdata[ST_UDF]) begin
                r_udf <= 1'b0;
            end

            if (w_commit_wr && (w_off == OFF_CMD)) begin
                r_cmd_data <= w_wdata;
            end
            if (w_commit_wr && (w_off == OFF_SCRATCH)) begin
                r_scratch <= w_wdata;
            end
        end
    end

    // Read data register carries no reset; it is only visible while r_rd_active.
    always_ff @(posedge i_clk) begin
        if (w_start_rd) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign o_full      = w_full;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_data  = r_cmd_data;

endmodule

// File: tb/tb_scomp_io_mailbox.sv
// -----------------------------------------------------------------------------
// tb_scomp_io_mailbox
// Drives SCOMP bus transactions and local pushes, keeps a transaction-level
// model of the mailbox (queue + sticky flags + registers) and compares the
// DUT outputs and the shared bus against it every cycle.
// The bus net is pulled high, so an undriven bus reads as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_scomp_io_mailbox;

    logic        clk;
    logic        reset_n;
    logic        sc_clk;
    logic        iocyc;
    logic        iowr;
    logic [7:0]  ioaddr;
    tri1  [15:0] sc_iodata;
    logic        push;
    logic [15:0] push_data;
    logic        full;
    logic        cmd_valid;
    logic [15:0] cmd_data;

    logic        tb_oe;
    logic [15:0] tb_drv;

    assign sc_iodata = tb_oe ? tb_drv : {16{1'bz}};

    scomp_io_mailbox #(
        .BASE_ADDR (8'h40),
        .FIFO_AW   (3)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_sc_clk     (sc_clk),
        .i_sc_iocyc   (iocyc),
        .i_sc_iowr    (iowr),
        .i_sc_ioaddr  (ioaddr),
        .io_sc_iodata (sc_iodata),
        .i_push       (push),
        .i_push_data  (push_data),
        .o_full       (full),
        .o_cmd_valid  (cmd_valid),
        .o_cmd_data   (cmd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    localparam int DEPTH = 8;
    logic [15:0] q[$];
    bit          m_ovf;
    bit          m_udf;
    logic [15:0] m_scratch;
    logic [15:0] m_cmd;
    bit          exp_cmd_valid;
    bit          exp_drive;
    logic [15:0] exp_val;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] status_word();
        logic [15:0] s;
        s = 16'h0000;
        s[0]   = (q.size() == 0);
        s[1]   = (q.size() == DEPTH);
        s[2]   = m_ovf;
        s[3]   = m_udf;
        s[7:4] = 4'(q.size());
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_scratch = 16'h0000;
        m_cmd = 16'h0000;
        exp_cmd_valid = 0;
        exp_drive = 0;
        exp_val = 16'h0000;
    endtask

    // Push takes effect after any pop of the same cycle has freed a slot.
    task automatic model_push(input logic [15:0] d);
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus", sc_iodata, tb_oe ? tb_drv : (exp_drive ? exp_val : 16'hFFFF));
            chk("full", {15'b0, full}, {15'b0, (q.size() == DEPTH)});
            chk("cmd_valid", {15'b0, cmd_valid}, {15'b0, exp_cmd_valid});
            chk("cmd_data", cmd_data, m_cmd);
        end
    end

    task automatic do_push(input logic [15:0] d);
        push = 1'b1;
        push_data = d;
        tick();
        model_push(d);
        push = 1'b0;
    endtask

    // One complete bridge transaction: rise with cycle asserted, fall, then
    // next rise drops iocyc. rd returns the bus value just before that rise.
    task automatic sc_xfer(input bit wr, input logic [7:0] addr, input logic [15:0] wd,
                           input bit push_fall, input logic [15:0] pd,
                           output logic [15:0] rd);
        bit          hit;
        logic [1:0]  off;
        bit          will_pop;
        logic [15:0] v;
        hit = (addr[7:2] == 6'h10);
        off = addr[1:0];
        will_pop = 0;
        v = 16'hFFFF;

        sc_clk = 1'b1; iocyc = 1'b1; iowr = wr; ioaddr = addr;
        tb_oe = wr; tb_drv = wd;
        tick();
        if (hit && !wr) begin
            case (off)
                2'd0: v = status_word();
                2'd1: begin
                    will_pop = (q.size() != 0);
                    v = will_pop ? q[0] : 16'h0000;
                end
                2'd2: v = m_cmd;
                default: v = m_scratch;
            endcase
            exp_val = v;
            exp_drive = 1;
        end
        repeat (3) tick();

        sc_clk = 1'b0;
        if (push_fall) begin
            push = 1'b1;
            push_data = pd;
        end
        tick();
        if (hit) begin
            if (!wr) begin
                if (off == 2'd1) begin
                    if (will_pop) void'(q.pop_front());
                    else m_udf = 1;
                end
            end else begin
                case (off)
                    2'd0: begin
                        if (wd[2]) m_ovf = 0;
                        if (wd[3]) m_udf = 0;
                    end
                    2'd2: begin
                        m_cmd = wd;
                        exp_cmd_valid = 1;
                    end
                    2'd3: m_scratch = wd;
                    default: ;
                endcase
            end
        end
        if (push_fall) begin
            model_push(pd);
            push = 1'b0;
        end
        tick();
        exp_cmd_valid = 0;
        repeat (2) tick();
        rd = sc_iodata;
        if (!wr) chk("xfer_rd", rd, v);

        sc_clk = 1'b1; iocyc = 1'b0; tb_oe = 1'b0; exp_drive = 0;
        tick();
        sc_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic sc_read(input logic [7:0] addr, output logic [15:0] rd);
        sc_xfer(1'b0, addr, 16'h0000, 1'b0, 16'h0000, rd);
    endtask

    task automatic sc_write(input logic [7:0] addr, input logic [15:0] wd);
        logic [15:0] dummy;
        sc_xfer(1'b1, addr, wd, 1'b0, 16'h0000, dummy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          seen_cmd_pulse;

        reset_n = 1'b0;
        sc_clk = 1'b0; iocyc = 1'b0; iowr = 1'b0; ioaddr = 8'h00;
        push = 1'b0; push_data = 16'h0000;
        tb_oe = 1'b0; tb_drv = 16'h0000;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        chk_en = 1;
        tick();

        // Reset state
        sc_read(8'h40, rd);
        chk("reset_status", rd, 16'h0001);

        // FIFO order through the DATA port
        do_push(16'hA5A5);
        do_push(16'h1234);
        sc_read(8'h41, rd);
        chk("data_first", rd, 16'hA5A5);
        sc_read(8'h41, rd);
        chk("data_second", rd, 16'h1234);
        sc_read(8'h40, rd);
        chk("status_drained", rd, 16'h0001);

        // Scratch round trip and address miss
        sc_write(8'h43, 16'hBEEF);
        sc_read(8'h43, rd);
        chk("scratch", rd, 16'hBEEF);
        sc_read(8'h50, rd);
        chk("miss_z", rd, 16'hFFFF);

        // CMD pulse: exactly one cycle after the fall is sampled
        seen_cmd_pulse = 0;
        fork
            sc_write(8'h42, 16'h00C3);
            repeat (14) begin
                @(negedge clk);
                if (cmd_valid) seen_cmd_pulse++;
            end
        join
        chk("cmd_pulse_count", 16'(seen_cmd_pulse), 16'd1);
        chk("cmd_data_lit", cmd_data, 16'h00C3);
        sc_read(8'h42, rd);
        chk("cmd_readback", rd, 16'h00C3);

        // Overflow on the 9th push, then clear it
        for (int i = 0; i < 9; i++) do_push(16'h1000 + 16'(i));
        sc_read(8'h40, rd);
        chk("status_ovf", rd, 16'h0086);
        sc_write(8'h40, 16'h0004);
        sc_read(8'h40, rd);
        chk("status_ovf_clr", rd, 16'h0082);

        // Full FIFO: pop and push in the same cycle
        sc_xfer(1'b0, 8'h41, 16'h0000, 1'b1, 16'h7777, rd);
        chk("pop_push_head", rd, 16'h1000);
        sc_read(8'h40, rd);
        chk("status_pop_push", rd, 16'h0082);
        for (int i = 0; i < 8; i++) sc_read(8'h41, rd);
        chk("pop_push_last", rd, 16'h7777);

        // Underflow
        sc_read(8'h41, rd);
        chk("underflow_data", rd, 16'h0000);
        sc_read(8'h40, rd);
        chk("status_udf", rd, 16'h0009);

        // Reset in the middle of a read cycle
        do_push(16'h5A5A);
        sc_clk = 1'b1; iocyc = 1'b1; iowr = 1'b0; ioaddr = 8'h41;
        tick();
        exp_val = 16'h5A5A;
        exp_drive = 1;
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_bus_release", sc_iodata, 16'hFFFF);
        sc_clk = 1'b0; iocyc = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        sc_read(8'h40, rd);
        chk("status_after_rst", rd, 16'h0001);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            int          kind;
            logic [7:0]  a;
            logic [15:0] d;
            kind = $urandom_range(0, 9);
            d = 16'($urandom);
            if (kind < 4) begin
                do_push(d);
            end else begin
                if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(0, 255));
                else a = 8'h40 + 8'($urandom_range(0, 3));
                sc_xfer(($urandom_range(0, 2) == 0), a, d,
                        ($urandom_range(0, 3) == 0), 16'($urandom), rd);
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
